// File: rtl/fpmu_result_tx_if.sv
// Result-side and host-side signals of the FPMU byte-serial transmitter.
// master = transmitter view, slave = core/host environment view.
interface fpmu_result_tx_if;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_flags;
  logic [7:0]  byte_out;
  logic        byte_strb;
  logic        byte_ack;
  logic        frame_last;
  logic        timeout_err;

  modport master (
    input  res_valid, res_data, res_flags, byte_ack,
    output res_ready, byte_out, byte_strb, frame_last, timeout_err
  );

  modport slave (
    output res_valid, res_data, res_flags, byte_ack,
    input  res_ready, byte_out, byte_strb, frame_last, timeout_err
  );
endinterface

// File: rtl/fpmu_result_tx.sv
// Sends {101,flags} then DATA_BYTES result bytes MSB first, one 4-phase strobe/ack per byte.
// Ack seen through 2 sync flops; a result is taken only in IDLE with ack released.
module fpmu_result_tx #(
  parameter int          DATA_BYTES  = 4,
  parameter logic [15:0] ACK_TIMEOUT = 16'd1000
) (
  input logic              clk,
  input logic              rst_n,
  fpmu_result_tx_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, RELEASE = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic                    ack_meta, ack_s;
  logic [8*DATA_BYTES-1:0] data_q, data_d;
  logic [7:0]              byte_q, byte_d, next_byte;
  logic                    strb_q, strb_d;
  logic                    last_q, last_d;
  logic                    err_q, err_d;
  logic [2:0]              idx_q, idx_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    accept, waiting, term, last_sent;

  assign bus.res_ready   = (state_q == IDLE) && !ack_s;
  assign bus.byte_out    = byte_q;
  assign bus.byte_strb   = strb_q;
  assign bus.frame_last  = last_q;
  assign bus.timeout_err = err_q;

  assign accept    = bus.res_valid && bus.res_ready;
  assign waiting   = ((state_q == DRIVE) && !ack_s) || ((state_q == RELEASE) && ack_s);
  assign term      = waiting && (cnt_q == ACK_TIMEOUT - 16'd1);
  assign last_sent = (idx_q == 3'(DATA_BYTES));

  // idx counts data bytes already sent, so the next one is byte DATA_BYTES-1-idx
  always_comb begin
    next_byte = 8'h00;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (idx_q == 3'(DATA_BYTES - 1 - i)) next_byte = data_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
      data_q   <= '0;
      byte_q   <= 8'h00;
      strb_q   <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= 3'd0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      ack_meta <= bus.byte_ack;
      ack_s    <= ack_meta;
      data_q   <= data_d;
      byte_q   <= byte_d;
      strb_q   <= strb_d;
      last_q   <= last_d;
      err_q    <= err_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
    end
  end

  // An ack arriving on the terminal count is checked first, so it wins over the abort
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = DRIVE;
      DRIVE: begin
        if (ack_s)     state_d = RELEASE;
        else if (term) state_d = IDLE;
      end
      RELEASE: begin
        if (!ack_s)    state_d = last_sent ? IDLE : DRIVE;
        else if (term) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d = data_q;
    byte_d = byte_q;
    strb_d = strb_q;
    last_d = last_q;
    err_d  = err_q;
    idx_d  = idx_q;
    cnt_d  = (waiting && !term) ? cnt_q + 16'd1 : 16'd0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d = bus.res_data[8*DATA_BYTES-1:0];
          byte_d = {3'b101, bus.res_flags};
          strb_d = 1'b1;
          last_d = 1'b0;
          err_d  = 1'b0;
          idx_d  = 3'd0;
        end
      end
      DRIVE: begin
        if (ack_s) begin
          strb_d = 1'b0;
        end else if (term) begin
          strb_d = 1'b0;
          last_d = 1'b0;
          err_d  = 1'b1;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          if (last_sent) begin
            last_d = 1'b0;
          end else begin
            idx_d  = idx_q + 3'd1;
            byte_d = next_byte;
            strb_d = 1'b1;
            last_d = (idx_q + 3'd1 == 3'(DATA_BYTES));
          end
        end else if (term) begin
          last_d = 1'b0;
          err_d  = 1'b1;
        end
      end
      default: begin
        strb_d = 1'b0;
        last_d = 1'b0;
      end
    endcase
  end
endmodule

// File: doc/fpmu_result_tx.md
Name: fpmu_result_tx

Overview:
- Byte-serial result transmitter for the FPMU; the send side of the 8-bit pin interface whose receive side loads operands on the dedicated inputs.
- Accepts one packed result word plus IEEE exception flags from the multiplier core.
- Sends the result as a framed byte sequence: a status byte, then data bytes MSB first.
- Each byte uses a 4-phase strobe/ack handshake with an external host.

Parameters:
- DATA_BYTES, 4, number of result data bytes per frame (1..4); frame length is DATA_BYTES+1.
- ACK_TIMEOUT, 16'd1000, cycles allowed per handshake phase before the frame is aborted (>=2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- res_valid  input  1  core presents a result.
- res_ready  output  1  transmitter can accept a result.
- res_data  input  32  result word; only bits [8*DATA_BYTES-1:0] are sent.
- res_flags  input  5  {NV,DZ,OF,UF,NX} exception flags.
- byte_out  output  8  byte presented to the host.
- byte_strb  output  1  byte_out is valid (host pin).
- byte_ack  input  1  host acknowledge; asynchronous to clk.
- frame_last  output  1  current byte is the last byte of the frame.
- timeout_err  output  1  sticky: the last frame was aborted on timeout.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; byte_out=8'h00, byte_strb=0, frame_last=0, timeout_err=0.
  - Sync flops, byte index and timeout counter all 0.
- byte_ack passes through a 2-flop synchronizer (reset 0) to form ack_s. All decisions use ack_s, giving 2 cycles of latency from the pin.
- res_ready = (state==IDLE) && !ack_s, combinational from registers. A frame never starts while the host still holds ack.
- Accept occurs on a clk edge with res_valid && res_ready. On that edge:
  - Latch res_data and res_flags.
  - byte_out <= {3'b101, res_flags}; byte_strb <= 1.
  - idx <= 0; timeout_err <= 0; state <= DRIVE.
  - frame_last <= (DATA_BYTES==0), which is always 0 for legal values.
- DRIVE (strobe high, waiting for ack_s=1):
  - On ack_s=1: byte_strb <= 0, state <= RELEASE, counter cleared. byte_out and frame_last hold.
- RELEASE (waiting for ack_s=0). On ack_s=0:
  - If idx==DATA_BYTES: frame complete. State <= IDLE, frame_last <= 0, byte_out holds last value.
  - Otherwise: idx <= idx+1; byte_out <= latched data byte (DATA_BYTES-1-idx), MSB first; byte_strb <= 1; frame_last <= (idx+1==DATA_BYTES); state <= DRIVE.
- Invariants:
  - byte_out changes only on the edge that raises byte_strb.
  - byte_out is stable whenever byte_strb=1 or the state is RELEASE.
- Timeout:
  - 16-bit counter, cleared on entry to DRIVE or RELEASE; increments each cycle the awaited condition is false.
  - When the counter equals ACK_TIMEOUT-1 and the condition is still false, the next edge forces state <= IDLE, byte_strb <= 0, frame_last <= 0, timeout_err <= 1.
  - The remaining bytes of the frame are discarded.
- timeout_err holds until the next accept clears it.
- ack_s is ignored in IDLE, apart from gating res_ready.
- res_valid is ignored outside IDLE; the core holds its result until accepted.
- Simultaneous ack_s arrival and timeout terminal count: ack wins, no abort.
- Frame cycle count with zero host delay: 1 accept edge + per byte (2 sync + 1 DRIVE, 2 sync + 1 RELEASE).

Test Plan:
- Reset, then res_data=32'h3FC00000, res_flags=5'b00001, with a host acking 3 cycles after strb and releasing 3 cycles after strb falls -> bytes A1, 3F, C0, 00, 00 in order; frame_last high only on the 5th byte; res_ready returns high after the final release.
- DATA_BYTES=2, res_data=32'h0000BEEF, flags 5'b10000 -> bytes B0, BE, EF; frame_last on EF.
- ACK_TIMEOUT=16, host never acks -> byte_strb falls exactly 16 cycles after entering DRIVE; timeout_err=1; state IDLE; the next accepted frame clears timeout_err.
- Host holds byte_ack high while idle, with res_valid=1 -> res_ready=0, no strobe; drop ack -> res_ready rises 2 cycles later and the frame starts.
- Assert rst_n=0 mid-frame during the 3rd byte in DRIVE -> outputs go to reset values immediately (asynchronously); after release, a new frame sends from the status byte.
- Ack arrives on the same cycle the counter hits terminal count -> the frame continues normally and timeout_err stays 0.
